// File: rtl/gray_decoder_if.sv
// Sample/result bundle between a Gray-code source and gray_decoder.
// The master drives samples in; the slave (decoder) returns decoded results and status.
interface gray_decoder_if #(
    parameter int WIDTH = 3
);
    logic             In_valid;
    logic [WIDTH-1:0] Gray_in;
    logic [WIDTH-1:0] Bin_out;
    logic             Out_valid;
    logic             Step_err;
    logic             Fault;
    logic             Overflow;
    logic [7:0]       Wrap_cnt;

    modport master (
        output In_valid, Gray_in,
        input  Bin_out, Out_valid, Step_err, Fault, Overflow, Wrap_cnt
    );

    modport slave (
        input  In_valid, Gray_in,
        output Bin_out, Out_valid, Step_err, Fault, Overflow, Wrap_cnt
    );
endinterface

// File: rtl/gray_decoder.sv
// Gray-to-binary stream decoder that validates single forward steps and counts wraps.
// A FAULT state latches the first illegal step; decoding continues but wrap tracking freezes.
module gray_decoder #(
    parameter int WIDTH = 3
) (
    input  logic          Clk,
    input  logic          Reset,
    gray_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] binOut_q, binOut_d;
    logic             outValid_q, outValid_d;
    logic             stepErr_q, stepErr_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       wrapCnt_q, wrapCnt_d;

    logic [WIDTH-1:0] newBin;
    logic [WIDTH-1:0] stepDiff;
    logic             isLegal;
    logic             isWrap;

    always_comb begin
        newBin = '0;
        newBin[WIDTH-1] = bus.Gray_in[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            newBin[i] = newBin[i+1] ^ bus.Gray_in[i];
        end
    end

    // The output register doubles as prev_bin: both always hold the last accepted sample.
    always_comb begin
        stepDiff = newBin - binOut_q;
        isLegal  = (stepDiff == '0) || (stepDiff == WIDTH'(1));
        isWrap   = (stepDiff == WIDTH'(1)) && (binOut_q == {WIDTH{1'b1}});
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            binOut_q   <= '0;
            outValid_q <= 1'b0;
            stepErr_q  <= 1'b0;
            overflow_q <= 1'b0;
            wrapCnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            binOut_q   <= binOut_d;
            outValid_q <= outValid_d;
            stepErr_q  <= stepErr_d;
            overflow_q <= overflow_d;
            wrapCnt_q  <= wrapCnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        binOut_d   = binOut_q;
        outValid_d = 1'b0;
        stepErr_d  = 1'b0;
        overflow_d = overflow_q;
        wrapCnt_d  = wrapCnt_q;

        if (bus.In_valid) begin
            binOut_d   = newBin;
            outValid_d = 1'b1;
            unique case (state_q)
                IDLE: begin
                    state_d = TRACK;
                end
                TRACK: begin
                    if (!isLegal) begin
                        stepErr_d = 1'b1;
                        state_d   = FAULT;
                    end else if (isWrap) begin
                        overflow_d = 1'b1;
                        if (wrapCnt_q != 8'hFF) begin
                            wrapCnt_d = wrapCnt_q + 8'd1;
                        end
                    end
                end
                FAULT: begin
                    stepErr_d = !isLegal;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.Bin_out   = binOut_q;
    assign bus.Out_valid = outValid_q;
    assign bus.Step_err  = stepErr_q;
    assign bus.Fault     = (state_q == FAULT);
    assign bus.Overflow  = overflow_q;
    assign bus.Wrap_cnt  = wrapCnt_q;

endmodule

// File: tb/tb_gray_decoder.sv
// Directed self-checking bench for gray_decoder at WIDTH = 3.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_gray_decoder;

    localparam int WIDTH = 3;

    logic Clk;
    logic Reset;

    int checkCount;
    int errorCount;

    logic [WIDTH-1:0] grayTab [8];

    gray_decoder_if #(.WIDTH(WIDTH)) bus ();

    gray_decoder #(.WIDTH(WIDTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] gray, input logic rst);
        @(negedge Clk);
        bus.In_valid = valid;
        bus.Gray_in  = gray;
        Reset        = rst;
        @(posedge Clk);
        #1;
    endtask

    task automatic sendSample(input logic [WIDTH-1:0] gray);
        applyStimulus(1'b1, gray, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_bin"},   32'(bus.Bin_out),   32'd0);
        checkOutput({tag, "_valid"}, 32'(bus.Out_valid), 32'd0);
        checkOutput({tag, "_err"},   32'(bus.Step_err),  32'd0);
        checkOutput({tag, "_fault"}, 32'(bus.Fault),     32'd0);
        checkOutput({tag, "_ovf"},   32'(bus.Overflow),  32'd0);
        checkOutput({tag, "_wrap"},  32'(bus.Wrap_cnt),  32'd0);
    endtask

    initial begin
        checkCount   = 0;
        errorCount   = 0;
        bus.In_valid = 1'b0;
        bus.Gray_in  = '0;
        Reset        = 1'b1;
        grayTab[0] = 3'b000; grayTab[1] = 3'b001; grayTab[2] = 3'b011; grayTab[3] = 3'b010;
        grayTab[4] = 3'b110; grayTab[5] = 3'b111; grayTab[6] = 3'b101; grayTab[7] = 3'b100;

        doReset();
        checkAllZero("reset");

        // Full legal count 0..7 then wrap to 0
        for (int i = 0; i < 9; i++) begin
            sendSample(grayTab[i % 8]);
            checkOutput($sformatf("seq_bin%0d", i), 32'(bus.Bin_out),   32'(i % 8));
            checkOutput($sformatf("seq_vld%0d", i), 32'(bus.Out_valid), 32'd1);
            checkOutput($sformatf("seq_err%0d", i), 32'(bus.Step_err),  32'd0);
        end
        checkOutput("seq_ovf",   32'(bus.Overflow), 32'd1);
        checkOutput("seq_wrap",  32'(bus.Wrap_cnt), 32'd1);
        checkOutput("seq_fault", 32'(bus.Fault),    32'd0);
        applyStimulus(1'b0, 3'b111, 1'b0);
        checkOutput("idle_vld", 32'(bus.Out_valid), 32'd0);
        checkOutput("idle_bin", 32'(bus.Bin_out),   32'd0);

        // First sample after reset is not step-checked
        doReset();
        sendSample(3'b110);
        checkOutput("first_bin",   32'(bus.Bin_out),   32'd4);
        checkOutput("first_vld",   32'(bus.Out_valid), 32'd1);
        checkOutput("first_err",   32'(bus.Step_err),  32'd0);
        checkOutput("first_fault", 32'(bus.Fault),     32'd0);
        sendSample(3'b111);
        checkOutput("second_bin", 32'(bus.Bin_out),  32'd5);
        checkOutput("second_err", 32'(bus.Step_err), 32'd0);

        // Repeat is legal, backward step faults, decoding continues in FAULT
        doReset();
        sendSample(3'b001);
        sendSample(3'b001);
        checkOutput("rep_err",   32'(bus.Step_err), 32'd0);
        checkOutput("rep_fault", 32'(bus.Fault),    32'd0);
        sendSample(3'b000);
        checkOutput("back_err",   32'(bus.Step_err), 32'd1);
        checkOutput("back_fault", 32'(bus.Fault),    32'd1);
        checkOutput("back_bin",   32'(bus.Bin_out),  32'd0);
        sendSample(3'b001);
        checkOutput("post_bin",   32'(bus.Bin_out),  32'd1);
        checkOutput("post_err",   32'(bus.Step_err), 32'd0);
        checkOutput("post_fault", 32'(bus.Fault),    32'd1);

        // Jump 0 -> 3 faults; later wraps are not counted
        doReset();
        sendSample(3'b000);
        sendSample(3'b010);
        checkOutput("jump_err",   32'(bus.Step_err), 32'd1);
        checkOutput("jump_fault", 32'(bus.Fault),    32'd1);
        checkOutput("jump_bin",   32'(bus.Bin_out),  32'd3);
        applyStimulus(1'b0, 3'b010, 1'b0);
        checkOutput("jump_pulse", 32'(bus.Step_err), 32'd0);
        for (int i = 4; i <= 8; i++) begin
            sendSample(grayTab[i % 8]);
            checkOutput($sformatf("fwrap_err%0d", i), 32'(bus.Step_err), 32'd0);
        end
        checkOutput("fwrap_bin",  32'(bus.Bin_out),  32'd0);
        checkOutput("fwrap_wrap", 32'(bus.Wrap_cnt), 32'd0);
        checkOutput("fwrap_ovf",  32'(bus.Overflow), 32'd0);

        // 300 wraps: counter saturates at 255
        doReset();
        sendSample(3'b000);
        for (int w = 1; w <= 300; w++) begin
            for (int i = 1; i <= 8; i++) begin
                sendSample(grayTab[i % 8]);
            end
            if (w == 1) begin
                checkOutput("sat_ovf1",  32'(bus.Overflow), 32'd1);
                checkOutput("sat_wrap1", 32'(bus.Wrap_cnt), 32'd1);
            end
            if (w == 255) begin
                checkOutput("sat_wrap255", 32'(bus.Wrap_cnt), 32'd255);
            end
        end
        checkOutput("sat_wrap",  32'(bus.Wrap_cnt), 32'd255);
        checkOutput("sat_ovf",   32'(bus.Overflow), 32'd1);
        checkOutput("sat_fault", 32'(bus.Fault),    32'd0);

        // Reset dominates a simultaneous sample and returns to IDLE
        applyStimulus(1'b1, 3'b100, 1'b1);
        checkAllZero("rstdom");
        sendSample(3'b011);
        checkOutput("rstnext_bin",   32'(bus.Bin_out),   32'd2);
        checkOutput("rstnext_vld",   32'(bus.Out_valid), 32'd1);
        checkOutput("rstnext_err",   32'(bus.Step_err),  32'd0);
        checkOutput("rstnext_fault", 32'(bus.Fault),     32'd0);

        applyStimulus(1'b0, '0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
